virtual_ds2431_byte_io: RTL
===========================

Name: virtual_ds2431_byte_io

Overview:
1-Wire slave byte transceiver for the virtual DS2431. It sits between the DQ pin and the ROM/memory command modules (MatchRom and the others), and serves their transTrig/nRxTx/ByteTransDone/receiveDat handshake. It converts master-timed bit slots into bytes (Rx), drives bytes onto DQ in master read slots (Tx), and detects bus reset and answers it with a presence pulse.

Parameters:
SAMPLE_CYC, 750, clocks from DQ falling edge to Rx sample point (15 us at 50 MHz)
TX0_HOLD_CYC, 1500, clocks DQ is held low for a Tx '0' bit (30 us)
RESET_MIN_CYC, 20000, consecutive low clocks that qualify as a bus reset (400 us)
PRESENCE_WAIT_CYC, 1500, clocks from reset release to presence start (30 us)
PRESENCE_LEN_CYC, 6000, presence pulse length (120 us)
CNT_W, 16, width of the timing counters

Ports:
clk  in  1  system clock
rst  in  1  asynchronous, active-high reset
dqIn  in  1  raw DQ pin level (asynchronous)
dqPullLow  out  1  1 = drive DQ low (open drain); 0 = release
transTrig  in  1  rising edge requests one byte transfer
nRxTx  in  1  0 = receive byte, 1 = transmit byte; sampled with the request
transDat  in  8  byte to transmit; sampled with the request
receiveDat  out  8  last received byte, LSB first on the wire
ByteTransDone  out  1  1 = idle/complete, 0 = byte in progress
busReset  out  1  one-cycle pulse when a bus reset ends

Behaviour:
- Reset values: dqPullLow=0, receiveDat=8'hff, ByteTransDone=1, busReset=0, state IDLE, DQ sync flops=1, counters=0.
- DQ input: 2-flop synchroniser, then a falling-edge detector (sync prev=1, cur=0). Slot timing counts from the edge-detect cycle.
- Request: transTrig is registered and its rising edge is detected.
  - In IDLE: latch nRxTx and transDat, set bit index=0, clear ByteTransDone on the next cycle, go to WAIT_SLOT.
  - In PRESENCE_WAIT/PRESENCE: hold the edge as pending; it is accepted on the cycle after return to IDLE.
  - While a byte is active: ignore the edge.
- States: IDLE, WAIT_SLOT, RX_SAMPLE, TX_DRIVE0, WAIT_HIGH, PRESENCE_WAIT, PRESENCE.
- WAIT_SLOT, on falling edge, by mode:
  - Rx: go to RX_SAMPLE.
  - Tx with current bit=1: go to WAIT_HIGH, no drive.
  - Tx with current bit=0: assert dqPullLow on the next cycle, go to TX_DRIVE0.
- RX_SAMPLE: at count==SAMPLE_CYC, shift the synced DQ into the MSB of the shift register (LSB first on the wire), then go to WAIT_HIGH.
- TX_DRIVE0: release dqPullLow at count==TX0_HOLD_CYC, then go to WAIT_HIGH.
- WAIT_HIGH: on synced DQ=1, increment the bit index.
  - Index 8, Rx: receiveDat<=shift register.
  - Index 8, either mode: ByteTransDone<=1, go to IDLE.
  - Otherwise: go to WAIT_SLOT.
- receiveDat changes only on Rx completion. It is valid on the cycle ByteTransDone rises and is held until the next completed Rx byte.
- Low counter: counts consecutive synced-low cycles while dqPullLow=0, saturating at RESET_MIN_CYC. It clears when DQ is high or dqPullLow=1. It is active in every state except PRESENCE.
- Low counter reaching RESET_MIN_CYC: set resetSeen, release dqPullLow, abort any byte (ByteTransDone<=1, receiveDat unchanged).
- Reset release: on the first synced DQ=1 with resetSeen, pulse busReset for 1 cycle and go to PRESENCE_WAIT.
- PRESENCE_WAIT: after PRESENCE_WAIT_CYC, go to PRESENCE.
- PRESENCE: dqPullLow=1 for PRESENCE_LEN_CYC, then release and go to IDLE.
- A new reset during PRESENCE_WAIT restarts detection. A falling edge during presence is ignored.
- Simultaneous request edge and reset qualification: the reset wins and the request is dropped.
- rst mid-operation: dqPullLow clears asynchronously; all outputs take their reset values.

Decomposition:
- Package/include virtual_ds2431_pkg: state encodings, default timing constants, and the RESET_MIN vs. slot timing sanity localparams shared with the later reset/command modules.
- One sub-module, virtual_ds2431_dq_sync: 2-flop synchroniser plus falling/rising edge flags, reset to 1.

Test Plan:
- Rx 0x2D: request with nRxTx=0; the master emits 8 write slots, LSB first (0: low 60 us; 1: low 5 us, 70 us period) -> receiveDat=8'h2d when ByteTransDone rises; dqPullLow never asserted.
- Tx 0xA5: request with nRxTx=1 and transDat=8'ha5; the master emits 8 read slots (low 2 us) -> dqPullLow asserted for exactly 1500 clocks on slots 1, 3, 4, 6 (0-based), released otherwise; ByteTransDone=1 after slot 7.
- Bus reset: DQ low 480 us, then released -> busReset pulse exactly one cycle; dqPullLow high for 6000 clocks starting 1500 clocks (+ sync latency) after release.
- Reset mid-byte: Rx of 0xC5 started, 3 slots sent, then 480 us low -> ByteTransDone=1 at qualification, receiveDat keeps its prior value, presence follows.
- Request during presence: transTrig rises while dqPullLow=1 in presence -> ByteTransDone stays 1 until presence ends, then drops; the following Rx of 0x40 completes correctly.
- Async reset during the Tx '0' drive: rst=1 -> dqPullLow=0 with no clock edge needed; after rst=0, ByteTransDone=1 and receiveDat=8'hff.

Source files
------------

// File: rtl/virtual_ds2431_pkg.sv
// Shared definitions for the virtual DS2431 1-Wire slave: byte-transceiver
// state encoding, default slot/reset timing at 50 MHz, and timing sanity values
// used by this block and by the reset/command modules built on top of it.
package virtual_ds2431_pkg;

  typedef enum logic [2:0] {
    ST_IDLE          = 3'd0,
    ST_WAIT_SLOT     = 3'd1,
    ST_RX_SAMPLE     = 3'd2,
    ST_TX_DRIVE0     = 3'd3,
    ST_WAIT_HIGH     = 3'd4,
    ST_PRESENCE_WAIT = 3'd5,
    ST_PRESENCE      = 3'd6
  } byteIoState_t;

  localparam int DEF_SAMPLE_CYC        = 750;    // 15 us
  localparam int DEF_TX0_HOLD_CYC      = 1500;   // 30 us
  localparam int DEF_RESET_MIN_CYC     = 20000;  // 400 us
  localparam int DEF_PRESENCE_WAIT_CYC = 1500;   // 30 us
  localparam int DEF_PRESENCE_LEN_CYC  = 6000;   // 120 us
  localparam int DEF_CNT_W             = 16;

  // Longest low time a master may legally hold inside a normal slot (120 us).
  localparam int DEF_SLOT_MAX_LOW_CYC  = 6000;

  localparam logic [7:0] RX_RESET_VAL  = 8'hff;

  // A reset must never be mistaken for a slot, and the sample point and the
  // Tx '0' hold must both land inside a slot.
  function automatic logic timingSane(input int sampleCyc, input int tx0HoldCyc,
                                      input int resetMinCyc, input int slotMaxLow);
    logic ok;
    ok = 1'b1;
    if (resetMinCyc <= slotMaxLow) begin
      ok = 1'b0;
    end else if (sampleCyc >= tx0HoldCyc) begin
      ok = 1'b0;
    end else if (tx0HoldCyc >= slotMaxLow) begin
      ok = 1'b0;
    end else begin
      ok = 1'b1;
    end
    return ok;
  endfunction

  localparam logic DEF_RESET_OVER_SLOT_OK = (DEF_RESET_MIN_CYC > DEF_SLOT_MAX_LOW_CYC);
  localparam logic DEF_TIMING_OK = timingSane(DEF_SAMPLE_CYC, DEF_TX0_HOLD_CYC,
                                              DEF_RESET_MIN_CYC, DEF_SLOT_MAX_LOW_CYC);

endpackage

// File: rtl/virtual_ds2431_dq_sync.sv
// DQ pin synchroniser: two flops bring the asynchronous pin into the clock
// domain, a third holds the previous synced level for edge flags. All reset to
// 1 (idle bus level) so no spurious falling edge appears out of reset.
module virtual_ds2431_dq_sync (
  input  logic clk,
  input  logic rst,
  input  logic dqIn,
  output logic dqSync,
  output logic dqFall,
  output logic dqRise
);

  logic meta_r;
  logic sync_r;
  logic prev_r;

  // Synchroniser chain plus one-cycle history of the synced level.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      meta_r <= 1'b1;
      sync_r <= 1'b1;
      prev_r <= 1'b1;
    end else begin
      meta_r <= dqIn;
      sync_r <= meta_r;
      prev_r <= sync_r;
    end
  end

  assign dqSync = sync_r;
  assign dqFall = prev_r & ~sync_r;
  assign dqRise = ~prev_r & sync_r;

endmodule

// File: rtl/virtual_ds2431_byte_io.sv
// 1-Wire slave byte transceiver for the virtual DS2431. Turns master-timed bit
// slots into bytes (Rx), drives bytes in read slots (Tx), detects bus reset and
// answers with a presence pulse. Talks to the command modules through the
// transTrig / nRxTx / ByteTransDone / receiveDat handshake.
module virtual_ds2431_byte_io
  import virtual_ds2431_pkg::*;
#(
  parameter int SAMPLE_CYC        = DEF_SAMPLE_CYC,
  parameter int TX0_HOLD_CYC      = DEF_TX0_HOLD_CYC,
  parameter int RESET_MIN_CYC     = DEF_RESET_MIN_CYC,
  parameter int PRESENCE_WAIT_CYC = DEF_PRESENCE_WAIT_CYC,
  parameter int PRESENCE_LEN_CYC  = DEF_PRESENCE_LEN_CYC,
  parameter int CNT_W             = DEF_CNT_W
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       dqIn,
  output logic       dqPullLow,
  input  logic       transTrig,
  input  logic       nRxTx,
  input  logic [7:0] transDat,
  output logic [7:0] receiveDat,
  output logic       ByteTransDone,
  output logic       busReset
);

  localparam logic [CNT_W-1:0] CNT_ZERO     = {CNT_W{1'b0}};
  localparam logic [CNT_W-1:0] CNT_ONE      = CNT_W'(1);
  localparam logic [CNT_W-1:0] SAMPLE_AT    = CNT_W'(SAMPLE_CYC);
  localparam logic [CNT_W-1:0] TX0_END      = CNT_W'(TX0_HOLD_CYC);
  localparam logic [CNT_W-1:0] RESET_SAT    = CNT_W'(RESET_MIN_CYC);
  localparam logic [CNT_W-1:0] RESET_QUAL   = CNT_W'(RESET_MIN_CYC - 1);
  localparam logic [CNT_W-1:0] PRES_WAIT_END = CNT_W'(PRESENCE_WAIT_CYC);
  localparam logic [CNT_W-1:0] PRES_LEN_END = CNT_W'(PRESENCE_LEN_CYC);

  logic dqSync_s;
  logic dqFall_s;
  logic dqRise_s;

  virtual_ds2431_dq_sync uDqSync (
    .clk    (clk),
    .rst    (rst),
    .dqIn   (dqIn),
    .dqSync (dqSync_s),
    .dqFall (dqFall_s),
    .dqRise (dqRise_s)
  );

  byteIoState_t     state_r;
  logic [CNT_W-1:0] cnt_r;
  logic [CNT_W-1:0] lowCnt_r;
  logic [3:0]       bitIdx_r;
  logic             txMode_r;
  logic [7:0]       txByte_r;
  logic [7:0]       shift_r;
  logic             resetSeen_r;
  logic             trigPrev_r;
  logic             reqPending_r;
  logic             pendMode_r;
  logic [7:0]       pendDat_r;

  logic reqEdge_s;
  logic qualify_s;

  // Request edge and the one-shot bus-reset qualification (counter just reaching
  // its limit while the line is still low and we are not driving it).
  always_comb begin
    reqEdge_s = transTrig & ~trigPrev_r;
    qualify_s = 1'b0;
    if ((state_r != ST_PRESENCE) && !dqSync_s && !dqPullLow && (lowCnt_r == RESET_QUAL)) begin
      qualify_s = 1'b1;
    end else begin
      qualify_s = 1'b0;
    end
  end

  // Main controller: low counter, reset/presence sequencing and bit-slot FSM.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_r       <= ST_IDLE;
      cnt_r         <= CNT_ZERO;
      lowCnt_r      <= CNT_ZERO;
      bitIdx_r      <= 4'd0;
      txMode_r      <= 1'b0;
      txByte_r      <= 8'h00;
      shift_r       <= 8'h00;
      resetSeen_r   <= 1'b0;
      trigPrev_r    <= 1'b0;
      reqPending_r  <= 1'b0;
      pendMode_r    <= 1'b0;
      pendDat_r     <= 8'h00;
      dqPullLow     <= 1'b0;
      receiveDat    <= RX_RESET_VAL;
      ByteTransDone <= 1'b1;
      busReset      <= 1'b0;
    end else begin
      trigPrev_r <= transTrig;
      busReset   <= 1'b0;

      if ((state_r == ST_PRESENCE) || dqSync_s || dqPullLow) begin
        lowCnt_r <= CNT_ZERO;
      end else if (lowCnt_r != RESET_SAT) begin
        lowCnt_r <= lowCnt_r + CNT_ONE;
      end else begin
        lowCnt_r <= lowCnt_r;
      end

      if (qualify_s) begin
        // Bus reset wins over everything, including a same-cycle request.
        resetSeen_r   <= 1'b1;
        dqPullLow     <= 1'b0;
        ByteTransDone <= 1'b1;
        reqPending_r  <= 1'b0;
        cnt_r         <= CNT_ZERO;
        state_r       <= ST_IDLE;
      end else if (resetSeen_r && dqRise_s) begin
        resetSeen_r <= 1'b0;
        busReset    <= 1'b1;
        cnt_r       <= CNT_ONE;
        state_r     <= ST_PRESENCE_WAIT;
        if (reqEdge_s) begin
          reqPending_r <= 1'b1;
          pendMode_r   <= nRxTx;
          pendDat_r    <= transDat;
        end
      end else begin
        case (state_r)
          ST_IDLE: begin
            if (resetSeen_r) begin
              // Bus still held in reset: park the request until presence ends.
              if (reqEdge_s) begin
                reqPending_r <= 1'b1;
                pendMode_r   <= nRxTx;
                pendDat_r    <= transDat;
              end
            end else if (reqEdge_s) begin
              reqPending_r  <= 1'b0;
              txMode_r      <= nRxTx;
              txByte_r      <= transDat;
              bitIdx_r      <= 4'd0;
              ByteTransDone <= 1'b0;
              state_r       <= ST_WAIT_SLOT;
            end else if (reqPending_r) begin
              reqPending_r  <= 1'b0;
              txMode_r      <= pendMode_r;
              txByte_r      <= pendDat_r;
              bitIdx_r      <= 4'd0;
              ByteTransDone <= 1'b0;
              state_r       <= ST_WAIT_SLOT;
            end
          end
          ST_WAIT_SLOT: begin
            if (dqFall_s) begin
              cnt_r <= CNT_ONE;
              if (!txMode_r) begin
                state_r <= ST_RX_SAMPLE;
              end else if (txByte_r[bitIdx_r[2:0]]) begin
                state_r <= ST_WAIT_HIGH;
              end else begin
                dqPullLow <= 1'b1;
                state_r   <= ST_TX_DRIVE0;
              end
            end
          end
          ST_RX_SAMPLE: begin
            if (cnt_r == SAMPLE_AT) begin
              shift_r <= {dqSync_s, shift_r[7:1]};
              state_r <= ST_WAIT_HIGH;
            end else begin
              cnt_r <= cnt_r + CNT_ONE;
            end
          end
          ST_TX_DRIVE0: begin
            if (cnt_r == TX0_END) begin
              dqPullLow <= 1'b0;
              state_r   <= ST_WAIT_HIGH;
            end else begin
              cnt_r <= cnt_r + CNT_ONE;
            end
          end
          ST_WAIT_HIGH: begin
            if (dqSync_s) begin
              bitIdx_r <= bitIdx_r + 4'd1;
              if (bitIdx_r == 4'd7) begin
                if (!txMode_r) begin
                  receiveDat <= shift_r;
                end
                ByteTransDone <= 1'b1;
                state_r       <= ST_IDLE;
              end else begin
                state_r <= ST_WAIT_SLOT;
              end
            end
          end
          ST_PRESENCE_WAIT: begin
            if (reqEdge_s) begin
              reqPending_r <= 1'b1;
              pendMode_r   <= nRxTx;
              pendDat_r    <= transDat;
            end
            if (cnt_r == PRES_WAIT_END) begin
              dqPullLow <= 1'b1;
              cnt_r     <= CNT_ONE;
              state_r   <= ST_PRESENCE;
            end else begin
              cnt_r <= cnt_r + CNT_ONE;
            end
          end
          ST_PRESENCE: begin
            if (reqEdge_s) begin
              reqPending_r <= 1'b1;
              pendMode_r   <= nRxTx;
              pendDat_r    <= transDat;
            end
            if (cnt_r == PRES_LEN_END) begin
              dqPullLow <= 1'b0;
              cnt_r     <= CNT_ZERO;
              state_r   <= ST_IDLE;
            end else begin
              cnt_r <= cnt_r + CNT_ONE;
            end
          end
          default: begin
            dqPullLow     <= 1'b0;
            ByteTransDone <= 1'b1;
            cnt_r         <= CNT_ZERO;
            state_r       <= ST_IDLE;
          end
        endcase
      end
    end
  end

endmodule
